cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_CDB, default `NUM_CDB, the number of CDB broadcast ports.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, the wait-cycle count at which a requester is promoted to starved priority.
REQ-003 SHALL have localparam NUM_REQ = `NUM_FU_MULT+`NUM_FU_MEM+`NUM_FU_BRANCH+`NUM_FU_ALU, giving the flat requester index order MULT, MEM, BRANCH, ALU (low to high).
REQ-004 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mispredict  input  1  flush; squashes grants and arbitration state.
REQ-007 SHALL have port fu_requests  input  FU_REQUESTS  per-FU CDB requests (alu/branch from issue, mult/mem from execute).
REQ-008 SHALL have port fu_grants  output  FU_GRANTS  per-FU one-bit grant, same structure as fu_requests.
REQ-009 SHALL have port cdb_valid  output  NUM_CDB  CDB port p carries a granted result.
REQ-010 SHALL have port cdb_src  output  NUM_CDB x $clog2(NUM_REQ)  flat index of the requester driving port p.
REQ-011 SHALL have port starved_dbg  output  NUM_REQ  requesters currently at or above STARVE_LIMIT.

Function
REQ-012 SHALL flatten fu_requests into req[NUM_REQ] in REQ-003 order and map grants back identically.
REQ-013 SHALL grant combinationally in the same cycle as the request (zero-cycle latency), since the issue stage clears FU slots with fu_grants in that cycle.
REQ-014 SHALL grant at most NUM_CDB requesters per cycle, each granted requester exactly once, and a grant only where req is 1.
REQ-015 SHALL fill ports in order: first the starved requesters (wait_cnt >= STARVE_LIMIT) in ascending index; then the remaining requesters in round-robin order starting at rr_ptr, wrapping from NUM_REQ-1 to 0.
REQ-016 SHALL fill CDB ports from port 0 upward in selection order; unused ports have cdb_valid=0 and cdb_src=0.
REQ-017 SHALL keep a per-requester counter wait_cnt of width $clog2(STARVE_LIMIT+1): +1 when requesting and not granted, saturating at STARVE_LIMIT; cleared when granted or when not requesting.
REQ-018 SHALL update rr_ptr, when any non-starved grant occurs, to (highest-round-robin-position non-starved granted index + 1) mod NUM_REQ; otherwise hold.
REQ-019 SHALL, when req is all zero, output all grants 0, leave rr_ptr unchanged and clear all wait_cnt.
REQ-020 SHALL, when requests <= NUM_CDB, grant every requester regardless of priority.
REQ-021 SHALL, while mispredict=1, drive fu_grants=0 and cdb_valid=0, and on the next edge set rr_ptr=0 and all wait_cnt=0.
REQ-022 SHALL give reset priority over mispredict; the two have identical state effects.

Reset
REQ-023 SHALL set rr_ptr=0 and all wait_cnt=0 at the clock edge where reset=1.
REQ-024 SHALL, while reset=1, drive fu_grants=0, cdb_valid=0, cdb_src=0 and starved_dbg=0.

Structure
REQ-025 SHALL take FU_REQUESTS, FU_GRANTS, `NUM_CDB and `NUM_FU_* from the shared sys_defs package; CDB_IDX (the $clog2(NUM_REQ) index type) SHALL be added there.
REQ-026 SHALL implement selection with one sub-module, rr_multi_picker: a parameterised N-request, K-grant rotating-priority picker that takes a pointer and a mask; it is instantiated twice (starved pass with pointer 0, normal pass with rr_ptr and the starved/taken requesters masked off).

Verification
REQ-027 SHALL cover: NUM_CDB=2, ALU0 and ALU1 requesting only, reset released -> both granted cycle 1, cdb_src = their flat indices, rr_ptr unchanged.
REQ-028 SHALL cover: all NUM_REQ requesting continuously, NUM_CDB=2 -> every requester granted within ceil(NUM_REQ/2)+STARVE_LIMIT cycles, and no wait_cnt exceeds STARVE_LIMIT.
REQ-029 SHALL cover: rr_ptr=NUM_REQ-1, requesters NUM_REQ-1 and 0 active -> both granted, NUM_REQ-1 on port 0 (wrap-around), next rr_ptr=1.
REQ-030 SHALL cover: MULT0 denied 4 cycles (STARVE_LIMIT=4) -> starved_dbg[0]=1, and on cycle 5 MULT0 is on port 0 ahead of round-robin winners.
REQ-031 SHALL cover: mispredict asserted with 3 requesters active -> zero grants that cycle, then rr_ptr=0 and wait_cnt all 0 next cycle.
REQ-032 SHALL cover: reset and mispredict asserted together mid-arbitration -> outputs 0 and state cleared; first grants after release follow rr_ptr=0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter slice.
// Purpose : functional-unit counts, CDB port count, the per-FU request/grant
//           record and the flat requester index type.
// Contents: SYS_NUM_* sizing constants, FU_REQUESTS / FU_GRANTS packed structs,
//           CDB_IDX index type, flatten_req / to_grants helpers.
// Flat requester order (low to high index): MULT, MEM, BRANCH, ALU.
package cdb_arbiter_pkg;

    localparam int SYS_NUM_CDB       = 2;
    localparam int SYS_NUM_FU_MULT   = 2;
    localparam int SYS_NUM_FU_MEM    = 3;
    localparam int SYS_NUM_FU_BRANCH = 2;
    localparam int SYS_NUM_FU_ALU    = 2;
    localparam int SYS_NUM_REQ       = SYS_NUM_FU_MULT + SYS_NUM_FU_MEM
                                     + SYS_NUM_FU_BRANCH + SYS_NUM_FU_ALU;
    localparam int CDB_IDX_W         = $clog2(SYS_NUM_REQ);

    // Offsets of each FU group inside the flat requester vector.
    localparam int MULT_LO   = 0;
    localparam int MEM_LO    = MULT_LO + SYS_NUM_FU_MULT;
    localparam int BRANCH_LO = MEM_LO + SYS_NUM_FU_MEM;
    localparam int ALU_LO    = BRANCH_LO + SYS_NUM_FU_BRANCH;

    typedef logic [CDB_IDX_W-1:0] CDB_IDX;

    typedef struct packed {
        logic [SYS_NUM_FU_ALU-1:0]    alu;
        logic [SYS_NUM_FU_BRANCH-1:0] branch;
        logic [SYS_NUM_FU_MEM-1:0]    mem;
        logic [SYS_NUM_FU_MULT-1:0]   mult;
    } FU_REQUESTS;

    // Grants mirror the request record one bit per FU.
    typedef FU_REQUESTS FU_GRANTS;

    function automatic logic [SYS_NUM_REQ-1:0] flatten_req(input FU_REQUESTS r);
        return {r.alu, r.branch, r.mem, r.mult};
    endfunction

    function automatic FU_GRANTS to_grants(input logic [SYS_NUM_REQ-1:0] v);
        FU_GRANTS g;
        g.mult   = v[MULT_LO   +: SYS_NUM_FU_MULT];
        g.mem    = v[MEM_LO    +: SYS_NUM_FU_MEM];
        g.branch = v[BRANCH_LO +: SYS_NUM_FU_BRANCH];
        g.alu    = v[ALU_LO    +: SYS_NUM_FU_ALU];
        return g;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Request/grant bus between the functional units and the CDB arbiter.
// Signals:
//   fu_requests  per-FU request to broadcast on a CDB port this cycle
//   fu_grants    per-FU grant, same record layout as fu_requests
//   cdb_valid    port p carries a granted result
//   cdb_src      flat requester index driving port p (0 when port unused)
//   starved_dbg  requesters whose wait count has reached the starve limit
// Handshake: a request is held by its FU until it sees the matching grant
// bit; the grant is combinational in the same cycle, is only ever asserted
// where the request bit is 1, and the FU treats request&grant as the transfer.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_CDB = SYS_NUM_CDB
) ();

    FU_REQUESTS                fu_requests;
    FU_GRANTS                  fu_grants;
    logic [NUM_CDB-1:0]        cdb_valid;
    CDB_IDX [NUM_CDB-1:0]      cdb_src;
    logic [SYS_NUM_REQ-1:0]    starved_dbg;

    // Functional-unit side.
    modport master (
        output fu_requests,
        input  fu_grants, cdb_valid, cdb_src, starved_dbg
    );

    // Arbiter side.
    modport slave (
        input  fu_requests,
        output fu_grants, cdb_valid, cdb_src, starved_dbg
    );

endinterface

// File: rtl/cdb_arbiter_rr_multi_picker.sv
// rr_multi_picker: N-request, K-grant rotating-priority picker.
// Ports:
//   req        request vector
//   mask       1 excludes that requester from this pass
//   ptr        index with highest priority; priority descends upward, wrapping
//   sel_valid  selection slot k holds a pick
//   sel_idx    index picked into slot k, in priority order
module rr_multi_picker #(
    parameter int N     = 4,
    parameter int K     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]            req,
    input  logic [N-1:0]            mask,
    input  logic [IDX_W-1:0]        ptr,
    output logic [K-1:0]            sel_valid,
    output logic [K-1:0][IDX_W-1:0] sel_idx
);

    localparam int CNT_W = $clog2(K + 1);

    logic [N-1:0]     eligible;
    logic [IDX_W:0]   pos;
    logic [CNT_W-1:0] cnt;

    assign eligible = req & ~mask;

    // Walk the N positions starting at ptr; the first K eligible requesters
    // fill the slots in the order they are met.
    always_comb begin
        sel_valid = '0;
        sel_idx   = '0;
        pos       = '0;
        cnt       = '0;
        for (int o = 0; o < N; o++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(o);
            if (pos >= (IDX_W+1)'(N)) begin
                pos = pos - (IDX_W+1)'(N);
            end
            if (eligible[pos[IDX_W-1:0]] && (cnt < CNT_W'(K))) begin
                for (int k = 0; k < K; k++) begin
                    if (cnt == CNT_W'(k)) begin
                        sel_valid[k] = 1'b1;
                        sel_idx[k]   = pos[IDX_W-1:0];
                    end
                end
                cnt = cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants up to NUM_CDB functional units a CDB port per cycle.
// Starved requesters (waited STARVE_LIMIT cycles) go first in ascending index,
// the rest fill remaining ports in round-robin order from rr_ptr.
// Ports:
//   clock       rising-edge clock
//   reset       synchronous active-high reset
//   mispredict  flush: kills this cycle's grants, clears arbitration state
//   bus         cdb_arbiter_if.slave (fu_requests in; fu_grants, cdb_valid,
//               cdb_src, starved_dbg out)
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_CDB      = SYS_NUM_CDB,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         mispredict,
    cdb_arbiter_if.slave bus
);

    localparam int NUM_REQ = SYS_NUM_FU_MULT + SYS_NUM_FU_MEM
                           + SYS_NUM_FU_BRANCH + SYS_NUM_FU_ALU;
    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int WAIT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int CNT_W   = $clog2(NUM_CDB + 1);

    logic [NUM_REQ-1:0]               req;
    logic [NUM_REQ-1:0]               starved;
    logic [NUM_REQ-1:0]               grant;
    logic [IDX_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0][WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [NUM_CDB-1:0]               s_valid, n_valid, port_valid;
    logic [NUM_CDB-1:0][IDX_W-1:0]    s_idx, n_idx, port_src;
    logic [CNT_W-1:0]                 num_starved;
    logic                             any_norm;
    logic [IDX_W-1:0]                 last_norm;
    logic                             flush;

    assign flush = reset | mispredict;
    assign req   = flatten_req(bus.fu_requests);

    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starved[i] = (wait_cnt_q[i] >= WAIT_W'(STARVE_LIMIT));
        end
    end

    // Starved pass: fixed pointer 0 gives ascending-index order.
    rr_multi_picker #(.N(NUM_REQ), .K(NUM_CDB), .IDX_W(IDX_W)) u_starved_pick (
        .req       (req),
        .mask      (~starved),
        .ptr       ('0),
        .sel_valid (s_valid),
        .sel_idx   (s_idx)
    );

    // Normal pass: starved requesters are handled (or out of ports) already.
    rr_multi_picker #(.N(NUM_REQ), .K(NUM_CDB), .IDX_W(IDX_W)) u_normal_pick (
        .req       (req),
        .mask      (starved),
        .ptr       (rr_ptr_q),
        .sel_valid (n_valid),
        .sel_idx   (n_idx)
    );

    // Ports 0..num_starved-1 take starved picks, the rest take normal picks in
    // order. The last normal pick placed is the furthest round-robin winner.
    always_comb begin
        num_starved = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            num_starved = num_starved + CNT_W'(s_valid[k]);
        end
        port_valid = '0;
        port_src   = '0;
        any_norm   = 1'b0;
        last_norm  = '0;
        for (int p = 0; p < NUM_CDB; p++) begin
            if (CNT_W'(p) < num_starved) begin
                port_valid[p] = 1'b1;
                port_src[p]   = s_idx[p];
            end else begin
                for (int j = 0; j < NUM_CDB; j++) begin
                    if ((CNT_W'(j) == (CNT_W'(p) - num_starved)) && n_valid[j]) begin
                        port_valid[p] = 1'b1;
                        port_src[p]   = n_idx[j];
                        any_norm      = 1'b1;
                        last_norm     = n_idx[j];
                    end
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int p = 0; p < NUM_CDB; p++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (port_valid[p] && (port_src[p] == IDX_W'(i))) begin
                    grant[i] = 1'b1;
                end
            end
        end
    end

    // Next-state for the round-robin pointer and the wait counters.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wait_cnt_d = '0;
        if (flush) begin
            rr_ptr_d = '0;
        end else begin
            if (any_norm) begin
                rr_ptr_d = (last_norm == IDX_W'(NUM_REQ - 1)) ? '0 : last_norm + 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && !grant[i]) begin
                    wait_cnt_d[i] = (wait_cnt_q[i] == WAIT_W'(STARVE_LIMIT))
                                  ? wait_cnt_q[i] : wait_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            wait_cnt_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        bus.fu_grants   = to_grants(flush ? '0 : grant);
        bus.cdb_valid   = flush ? '0 : port_valid;
        bus.cdb_src     = flush ? '0 : port_src;
        bus.starved_dbg = reset ? '0 : starved;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based reference of the arbitration rules.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NUM_CDB      = SYS_NUM_CDB;
    localparam int STARVE_LIMIT = 4;
    localparam int NUM_REQ      = SYS_NUM_REQ;
    localparam int IDX_W        = CDB_IDX_W;
    localparam int DENY_BOUND   = (NUM_REQ + 1) / 2 + STARVE_LIMIT - 1;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;
    logic mispredict;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    cdb_arbiter_if #(.NUM_CDB(NUM_CDB)) bus_if ();

    cdb_arbiter #(.NUM_CDB(NUM_CDB), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock      (clock),
        .reset      (reset),
        .mispredict (mispredict),
        .bus        (bus_if)
    );

    // ---------------- scoreboard state ----------------
    int tests;
    int fails;
    logic [IDX_W-1:0] exp_q[$];
    int m_rr;
    int m_wait[NUM_REQ];

    logic [NUM_REQ-1:0]            obs_grant;
    logic [NUM_CDB-1:0]            obs_valid;
    logic [NUM_CDB-1:0][IDX_W-1:0] obs_src;
    logic [NUM_REQ-1:0]            obs_stv;

    function automatic FU_REQUESTS to_req(input logic [NUM_REQ-1:0] v);
        FU_REQUESTS r;
        r.mult   = v[MULT_LO   +: SYS_NUM_FU_MULT];
        r.mem    = v[MEM_LO    +: SYS_NUM_FU_MEM];
        r.branch = v[BRANCH_LO +: SYS_NUM_FU_BRANCH];
        r.alu    = v[ALU_LO    +: SYS_NUM_FU_ALU];
        return r;
    endfunction

    function automatic logic [NUM_REQ-1:0] flat_g(input FU_GRANTS g);
        return {g.alu, g.branch, g.mem, g.mult};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver + reference model ----------------
    task automatic step(input logic [NUM_REQ-1:0] r, input logic misp, input logic rst);
        logic [NUM_REQ-1:0]            exp_g;
        logic [NUM_CDB-1:0]            exp_v;
        logic [NUM_CDB-1:0][IDX_W-1:0] exp_src;
        logic [NUM_REQ-1:0]            exp_stv;
        logic [IDX_W-1:0]              idx;
        int n_starved;
        int last_norm;
        int i;
        @(negedge clock);
        reset      = rst;
        mispredict = misp;
        bus_if.fu_requests = to_req(r);
        #1;
        exp_q.delete();
        exp_g   = '0;
        exp_v   = '0;
        exp_src = '0;
        exp_stv = '0;
        last_norm = -1;
        for (int k = 0; k < NUM_REQ; k++) exp_stv[k] = !rst && (m_wait[k] >= STARVE_LIMIT);
        if (!(rst || misp)) begin
            for (int k = 0; k < NUM_REQ; k++)
                if (r[k] && m_wait[k] >= STARVE_LIMIT) exp_q.push_back(IDX_W'(k));
            n_starved = exp_q.size();
            for (int o = 0; o < NUM_REQ; o++) begin
                i = (m_rr + o) % NUM_REQ;
                if (r[i] && m_wait[i] < STARVE_LIMIT) exp_q.push_back(IDX_W'(i));
            end
            for (int p = 0; p < NUM_CDB; p++) begin
                if (exp_q.size() > 0) begin
                    idx = exp_q.pop_front();
                    exp_v[p]   = 1'b1;
                    exp_src[p] = idx;
                    exp_g[idx] = 1'b1;
                    if (p >= n_starved) last_norm = int'(idx);
                end
            end
        end
        obs_grant = flat_g(bus_if.fu_grants);
        obs_valid = bus_if.cdb_valid;
        obs_src   = bus_if.cdb_src;
        obs_stv   = bus_if.starved_dbg;
        check("fu_grants",   64'(obs_grant), 64'(exp_g));
        check("cdb_valid",   64'(obs_valid), 64'(exp_v));
        check("cdb_src",     64'(obs_src),   64'(exp_src));
        check("starved_dbg", 64'(obs_stv),   64'(exp_stv));
        if (rst || misp) begin
            m_rr = 0;
            for (int k = 0; k < NUM_REQ; k++) m_wait[k] = 0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++)
                m_wait[k] = (r[k] && !exp_g[k]) ? ((m_wait[k] + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_wait[k] + 1) : 0;
            if (last_norm >= 0) m_rr = (last_norm + 1) % NUM_REQ;
        end
    endtask

    function automatic logic [NUM_REQ-1:0] bits2(input int a, input int b);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[a] = 1'b1;
        v[b] = 1'b1;
        return v;
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [NUM_REQ-1:0] all_ones;
        logic [NUM_REQ-1:0] v;
        int denied[NUM_REQ];
        int max_denied;
        tests = 0;
        fails = 0;
        m_rr  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            m_wait[k] = 0;
            denied[k] = 0;
        end
        all_ones   = '1;
        reset      = 1'b1;
        mispredict = 1'b0;
        bus_if.fu_requests = '0;

        // Reset holds every output low even with requests present.
        step(all_ones, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);

        // Two ALUs only: both granted on release, at their flat indices.
        step(bits2(ALU_LO, ALU_LO + 1), 1'b0, 1'b0);
        check("alu_pair_valid", 64'(obs_valid), 64'(2'b11));
        check("alu_pair_src", 64'(obs_src), 64'({IDX_W'(ALU_LO + 1), IDX_W'(ALU_LO)}));
        step(bits2(0, 1), 1'b0, 1'b0);
        check("rr_held_src", 64'(obs_src), 64'({IDX_W'(1), IDX_W'(0)}));

        // Wrap-around: move pointer to NUM_REQ-1, then top and bottom requesters.
        v = '0; v[NUM_REQ-2] = 1'b1;
        step(v, 1'b0, 1'b0);
        step(bits2(NUM_REQ - 1, 0), 1'b0, 1'b0);
        check("wrap_src", 64'(obs_src), 64'({IDX_W'(0), IDX_W'(NUM_REQ - 1)}));
        step(bits2(0, 1) | bits2(2, 2), 1'b0, 1'b0);
        check("after_wrap_src", 64'(obs_src), 64'({IDX_W'(2), IDX_W'(1)}));

        // Starve MULT0: pointer at 1, then pairs always ahead of it for 4 cycles.
        step('0, 1'b0, 1'b0);
        step(bits2(0, 0), 1'b0, 1'b0);
        for (int c = 0; c < STARVE_LIMIT; c++) begin
            step(bits2(0, 0) | bits2(1 + 2 * c, 2 + 2 * c), 1'b0, 1'b0);
        end
        step(bits2(0, 1) | bits2(2, 2), 1'b0, 1'b0);
        check("mult0_starved_dbg", 64'(obs_stv[0]), 64'(1'b1));
        check("mult0_port0", 64'(obs_src[0]), 64'(IDX_W'(0)));

        // Mispredict with three requesters: no grants, then pointer back at 0.
        step(all_ones, 1'b0, 1'b0);
        step(bits2(1, 3) | bits2(5, 5), 1'b1, 1'b0);
        check("misp_grants", 64'(obs_grant), 64'(0));
        check("misp_valid", 64'(obs_valid), 64'(0));
        step(bits2(0, 1) | bits2(2, 2), 1'b0, 1'b0);
        check("post_misp_src", 64'(obs_src), 64'({IDX_W'(1), IDX_W'(0)}));

        // Reset and mispredict together mid-arbitration.
        for (int c = 0; c < 3; c++) step(all_ones, 1'b0, 1'b0);
        step(all_ones, 1'b1, 1'b1);
        check("rst_misp_grants", 64'(obs_grant), 64'(0));
        step(bits2(3, 4) | bits2(5, 5), 1'b0, 1'b0);
        check("post_rst_src", 64'(obs_src), 64'({IDX_W'(4), IDX_W'(3)}));

        // Everyone requesting continuously: bounded wait for each requester.
        step('0, 1'b0, 1'b0);
        max_denied = 0;
        for (int c = 0; c < 24; c++) begin
            step(all_ones, 1'b0, 1'b0);
            for (int k = 0; k < NUM_REQ; k++) begin
                denied[k] = obs_grant[k] ? 0 : denied[k] + 1;
                if (denied[k] > max_denied) max_denied = denied[k];
            end
        end
        check("all_req_deny_bound", 64'(max_denied <= DENY_BOUND), 64'(1'b1));

        // Random traffic with occasional flushes and resets.
        for (int c = 0; c < 500; c++) begin
            v = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            if ($urandom_range(0, 1) == 1) v = v | NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            step(v, ($urandom_range(0, 24) == 0), ($urandom_range(0, 59) == 0));
        end

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
